// File: rtl/hashin_unpack_if.sv
// ---------------------------------------------------------------------------
// hashin_unpack_if
// Groups the two handshakes of the hashin unpacker.
//   FIFO side : hashin_fifo_dout / hashin_fifo_empty (FWFT head), hashin_fifo_re (pop)
//   Block side: blk_data / blk_valid / blk_last towards the hash core, blk_ready back
// master = the unpacker, slave = its environment (FIFO + hash core).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface hashin_unpack_if;
    logic [63:0]  hashin_fifo_dout;
    logic         hashin_fifo_empty;
    logic         hashin_fifo_re;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready;

    modport master (
        input  hashin_fifo_dout, hashin_fifo_empty, blk_ready,
        output hashin_fifo_re, blk_data, blk_valid, blk_last
    );

    modport slave (
        output hashin_fifo_dout, hashin_fifo_empty, blk_ready,
        input  hashin_fifo_re, blk_data, blk_valid, blk_last
    );
endinterface

// File: rtl/hashin_unpack.sv
// ---------------------------------------------------------------------------
// hashin_unpack
// Pops tag-prefixed packets (TAG + HDR_WORDS x 64-bit words) from the hashin
// FIFO, assembles the block header and hands it to the hash core as two
// padded 512-bit SHA-256 message blocks.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stop              synchronous abort, returns to IDLE without counting
//   bus (master)      FIFO pop interface and block valid/ready interface
//   stop_ack_unpack   high while idle
//   hdr_cnt           headers fully delivered (wraps)
//   err_cnt           non-tag words discarded while idle (saturates)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module hashin_unpack #(
    parameter logic [63:0] TAG       = 64'h8000000000000280,
    parameter int          HDR_WORDS = 10,
    parameter int          ERR_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stop,
    hashin_unpack_if.master      bus,
    output logic                 stop_ack_unpack,
    output logic [31:0]          hdr_cnt,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int HDR_W  = 64 * HDR_WORDS;
    // Header bits left over for the second block, and the zero fill between
    // the 0x80 pad byte and the 64-bit length field.
    localparam int TAIL_W = HDR_W - 512;
    localparam int ZERO_W = 512 - TAIL_W - 8 - 64;
    localparam int CNT_W  = $clog2(HDR_WORDS);

    typedef enum logic [1:0] {IDLE, COLLECT, SEND1, SEND2} state_t;

    state_t             state, state_n;
    logic [HDR_W-1:0]   hdr;
    logic [CNT_W-1:0]   cnt;
    logic               pop;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign pop = ((state == IDLE) || (state == COLLECT)) && !bus.hashin_fifo_empty && !stop;
    assign bus.hashin_fifo_re = pop;
    assign stop_ack_unpack    = (state == IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pop && bus.hashin_fifo_dout == TAG) state_n = COLLECT;
            COLLECT: if (pop && cnt == CNT_W'(HDR_WORDS - 1)) state_n = SEND1;
            SEND1:   if (bus.blk_ready) state_n = SEND2;
            SEND2:   if (bus.blk_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Abort wins over any handshake completing in the same cycle.
        if (stop) state_n = IDLE;
    end

    // Outputs depend on registered state only, so data is stable under backpressure.
    always_comb begin
        bus.blk_valid = 1'b0;
        bus.blk_last  = 1'b0;
        bus.blk_data  = '0;
        case (state)
            SEND1: begin
                bus.blk_valid = 1'b1;
                bus.blk_data  = hdr[HDR_W-1 -: 512];
            end
            SEND2: begin
                bus.blk_valid = 1'b1;
                bus.blk_last  = 1'b1;
                bus.blk_data  = {hdr[TAIL_W-1:0], 8'h80, {ZERO_W{1'b0}}, 64'(HDR_W)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hdr     <= '0;
            cnt     <= '0;
            hdr_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            if (!stop) begin
                case (state)
                    IDLE: if (pop) begin
                        if (bus.hashin_fifo_dout == TAG) cnt <= '0;
                        else                              err_cnt <= sat_inc(err_cnt);
                    end
                    // A word equal to TAG inside a packet is plain data.
                    COLLECT: if (pop) begin
                        hdr <= {hdr[HDR_W-65:0], bus.hashin_fifo_dout};
                        cnt <= cnt + CNT_W'(1);
                    end
                    SEND2: if (bus.blk_ready) hdr_cnt <= hdr_cnt + 32'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
